// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Purpose : shared types and constants for the alu_share_arbiter block.
//           Holds the function codes, the FSM state enum, the operand latch
//           payload and the fixed widths.
// Ports   : none (package).
// Config  : ALU_ARB_STATS_EN (optional per-requester grant counters) is
//           consumed by alu_arb_if and alu_share_arbiter, not here.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned RES_W = 8;
   localparam int unsigned FN_W  = 2;
   localparam int unsigned CNT_W = 8;

   localparam logic [FN_W-1:0] FN_ADD = 2'd0;
   localparam logic [FN_W-1:0] FN_OR  = 2'd1;
   localparam logic [FN_W-1:0] FN_AND = 2'd2;
   localparam logic [FN_W-1:0] FN_CAT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Operands and function code captured from the winning requester
   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic [FN_W-1:0] fn;
   } op_t;

endpackage

// File: rtl/alu_arb_if.sv
// ---------------------------------------------------------------------------
// alu_arb_if
// Purpose : bundles the two requester channels and the shared response
//           signals of alu_share_arbiter.
// Signals : Req0/A0/B0/Fn0, Req1/A1/B1/Fn1 (requester -> arbiter)
//           Ack0, Ack1, Result, GrantId, Busy (arbiter -> requesters)
//           Count0, Count1 only when ALU_ARB_STATS_EN is defined.
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_arb_if;
   import alu_arb_pkg::*;

   logic             Req0;
   logic [OP_W-1:0]  A0;
   logic [OP_W-1:0]  B0;
   logic [FN_W-1:0]  Fn0;
   logic             Req1;
   logic [OP_W-1:0]  A1;
   logic [OP_W-1:0]  B1;
   logic [FN_W-1:0]  Fn1;
   logic             Ack0;
   logic             Ack1;
   logic [RES_W-1:0] Result;
   logic             GrantId;
   logic             Busy;

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] Count0;
   logic [CNT_W-1:0] Count1;

   modport master (
      output Req0, A0, B0, Fn0, Req1, A1, B1, Fn1,
      input  Ack0, Ack1, Result, GrantId, Busy, Count0, Count1
   );
   modport slave (
      input  Req0, A0, B0, Fn0, Req1, A1, B1, Fn1,
      output Ack0, Ack1, Result, GrantId, Busy, Count0, Count1
   );
`else
   modport master (
      output Req0, A0, B0, Fn0, Req1, A1, B1, Fn1,
      input  Ack0, Ack1, Result, GrantId, Busy
   );
   modport slave (
      input  Req0, A0, B0, Fn0, Req1, A1, B1, Fn1,
      output Ack0, Ack1, Result, GrantId, Busy
   );
`endif

endinterface

// File: rtl/alu_share_arbiter_alu4.sv
// ---------------------------------------------------------------------------
// alu4
// Purpose : purely combinational 4-bit ALU with four functions:
//           add (ripple carry, carry out in bit 4), reduction OR of both
//           operands, reduction AND of both operands, concatenation.
// Ports   : i_a, i_b  operands (OP_W)
//           i_fn      function code (FN_W)
//           o_res_c   combinational result (RES_W)
// ---------------------------------------------------------------------------
module alu4
   import alu_arb_pkg::*;
(
   input  logic [OP_W-1:0]  i_a,
   input  logic [OP_W-1:0]  i_b,
   input  logic [FN_W-1:0]  i_fn,
   output logic [RES_W-1:0] o_res_c
);

   logic [OP_W-1:0] w_sum;
   logic            w_carry;

   // Ripple-carry adder; the carry is threaded through a single variable
   always_comb begin
      w_carry = 1'b0;
      w_sum   = '0;
      for (int i = 0; i < int'(OP_W); i++) begin
         w_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
         w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
      end
   end

   // Function select
   always_comb begin
      o_res_c = '0;
      case (i_fn)
         FN_ADD:  o_res_c = {3'b000, w_carry, w_sum};
         FN_OR:   o_res_c = {7'b0000000, |{i_a, i_b}};
         FN_AND:  o_res_c = {7'b0000000, &{i_a, i_b}};
         FN_CAT:  o_res_c = {i_a, i_b};
         default: o_res_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Purpose : round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one
//           alu4 between two level-requesting clients. One operation per
//           three cycles; registered result with a one-cycle Ack pulse.
// Ports   : Clock  rising-edge clock
//           Reset  asynchronous, active-high reset
//           bus    alu_arb_if.slave (requests/operands in; Ack0/Ack1,
//                  Result, GrantId, Busy, optional Count0/Count1 out)
// Config  : ALU_ARB_STATS_EN adds saturating 8-bit grant counters
//           Count0/Count1 on the interface.
// ---------------------------------------------------------------------------
module alu_share_arbiter
   import alu_arb_pkg::*;
(
   input  logic     Clock,
   input  logic     Reset,
   alu_arb_if.slave bus
);

   state_e           r_state, w_state_nxt;
   op_t              r_op, w_op_nxt;
   logic             r_grant, w_grant_nxt;
   logic             r_last, w_last_nxt;
   logic             r_ack0, w_ack0_nxt;
   logic             r_ack1, w_ack1_nxt;
   logic             r_busy, w_busy_nxt;
   logic [RES_W-1:0] r_result, w_result_nxt;
   logic [RES_W-1:0] w_alu_res;
   logic             w_win;

   alu4 u_alu4 (
      .i_a     (r_op.a),
      .i_b     (r_op.b),
      .i_fn    (r_op.fn),
      .o_res_c (w_alu_res)
   );

   // State register and registered outputs
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_grant  <= 1'b0;
         r_last   <= 1'b1;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_busy   <= 1'b0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_grant  <= w_grant_nxt;
         r_last   <= w_last_nxt;
         r_ack0   <= w_ack0_nxt;
         r_ack1   <= w_ack1_nxt;
         r_busy   <= w_busy_nxt;
         r_result <= w_result_nxt;
      end
   end

   // Next state and next registered outputs
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_grant_nxt  = r_grant;
      w_last_nxt   = r_last;
      w_result_nxt = r_result;
      w_ack0_nxt   = 1'b0;
      w_ack1_nxt   = 1'b0;
      w_busy_nxt   = 1'b0;

      // On a tie the requester not granted last wins
      w_win = (bus.Req0 && bus.Req1) ? ~r_last : bus.Req1;

      case (r_state)
         IDLE: begin
            if (bus.Req0 || bus.Req1) begin
               w_state_nxt = EXEC;
               w_grant_nxt = w_win;
               w_busy_nxt  = 1'b1;
               w_op_nxt    = w_win ? '{a: bus.A1, b: bus.B1, fn: bus.Fn1}
                                   : '{a: bus.A0, b: bus.B0, fn: bus.Fn0};
            end
         end
         EXEC: begin
            // Ack is registered, so it is raised on entry to RESP
            w_state_nxt  = RESP;
            w_result_nxt = w_alu_res;
            w_busy_nxt   = 1'b1;
            w_ack0_nxt   = ~r_grant;
            w_ack1_nxt   = r_grant;
         end
         RESP: begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_grant;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.Ack0    = r_ack0;
   assign bus.Ack1    = r_ack1;
   assign bus.Result  = r_result;
   assign bus.GrantId = r_grant;
   assign bus.Busy    = r_busy;

`ifdef ALU_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt0, w_cnt0_nxt;
   logic [CNT_W-1:0] r_cnt1, w_cnt1_nxt;

   // Saturating per-requester completion counters
   always_comb begin
      w_cnt0_nxt = r_cnt0;
      w_cnt1_nxt = r_cnt1;
      if (r_state == RESP) begin
         if (!r_grant && (r_cnt0 != CNT_MAX)) w_cnt0_nxt = r_cnt0 + CNT_W'(1);
         if (r_grant && (r_cnt1 != CNT_MAX))  w_cnt1_nxt = r_cnt1 + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         r_cnt0 <= w_cnt0_nxt;
         r_cnt1 <= w_cnt1_nxt;
      end
   end

   assign bus.Count0 = r_cnt0;
   assign bus.Count1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Purpose : self-checking bench for alu_share_arbiter: directed steps
//           followed by randomized traffic checked against a reference
//           model of the arbitration and ALU rules. Counter checks are
//           included when ALU_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: last granted requester and last result
   int         m_last = 1;
   logic [7:0] m_res  = 8'h00;

   alu_arb_if bus ();

   alu_share_arbiter dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ALU computed with plain arithmetic
   function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] fn);
      case (fn)
         2'd0:    return 8'(a) + 8'(b);
         2'd1:    return (a != 4'h0 || b != 4'h0) ? 8'd1 : 8'd0;
         2'd2:    return (a == 4'hF && b == 4'hF) ? 8'd1 : 8'd0;
         default: return 8'(a) * 8'd16 + 8'(b);
      endcase
   endfunction

   function automatic int ref_pick(input logic r0, input logic r1);
      if (r0 && r1) return 1 - m_last;
      return r1 ? 1 : 0;
   endfunction

   task automatic drive(input logic r0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [1:0] f0, input logic r1, input logic [3:0] a1,
                        input logic [3:0] b1, input logic [1:0] f1);
      bus.Req0 = r0; bus.A0 = a0; bus.B0 = b0; bus.Fn0 = f0;
      bus.Req1 = r1; bus.A1 = a1; bus.B1 = b1; bus.Fn1 = f1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last = 1;
      m_res  = 8'h00;
   endtask

   // One transaction whose request is sampled at the next rising edge.
   // mode 1: scramble all inputs during EXEC; mode 2: A0=0 and Req0=0 during EXEC.
   task automatic txn(input int id, input logic [7:0] res, input int mode);
      @(posedge clk); @(negedge clk);
      chk("busy_exec", 8'(bus.Busy), 8'd1);
      chk("ack_exec", {6'd0, bus.Ack1, bus.Ack0}, 8'd0);
      chk("grant_id", 8'(bus.GrantId), 8'(id));
      if (mode == 1)
         drive(1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
               1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
      else if (mode == 2) begin
         bus.A0 = 4'h0; bus.Req0 = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      chk("busy_resp", 8'(bus.Busy), 8'd1);
      chk("ack_resp", {6'd0, bus.Ack1, bus.Ack0}, (id == 1) ? 8'd2 : 8'd1);
      chk("result", bus.Result, res);
      @(posedge clk); @(negedge clk);
      chk("busy_idle", 8'(bus.Busy), 8'd0);
      chk("ack_idle", {6'd0, bus.Ack1, bus.Ack0}, 8'd0);
      chk("result_hold", bus.Result, res);
      m_last = id;
      m_res  = res;
   endtask

   initial begin
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ack", {6'd0, bus.Ack1, bus.Ack0}, 8'd0);
      chk("rst_busy", 8'(bus.Busy), 8'd0);
      chk("rst_grant", 8'(bus.GrantId), 8'd0);
      chk("rst_result", bus.Result, 8'h00);
`ifdef ALU_ARB_STATS_EN
      chk("rst_count0", bus.Count0, 8'h00);
      chk("rst_count1", bus.Count1, 8'h00);
`endif
      rst = 1'b0;

      // Single requester 0: F + 1 with carry
      drive(1'b1, 4'hF, 4'h1, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);
      txn(0, 8'h10, 0);
      bus.Req0 = 1'b0;

      // Single requester 1: OR of zeros, then AND of all ones
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 4'h0, 4'h0, 2'd1);
      txn(1, 8'h00, 0);
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b1, 4'hF, 4'hF, 2'd2);
      txn(1, 8'h01, 0);
      bus.Req1 = 1'b0;

      // Continuous contention from reset: strict alternation starting at 0
      apply_reset();
      drive(1'b1, 4'hA, 4'h5, 2'd3, 1'b1, 4'h3, 4'hC, 2'd3);
      txn(0, 8'hA5, 0);
      txn(1, 8'h3C, 0);
      txn(0, 8'hA5, 0);
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);
      @(posedge clk); @(negedge clk);
      chk("no_req_idle", 8'(bus.Busy), 8'd0);

      // Operands changed and Req0 dropped during EXEC are ignored
      drive(1'b1, 4'h7, 4'h2, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);
      txn(0, 8'h09, 2);
      @(posedge clk); @(negedge clk);
      chk("dropped_req_idle", 8'(bus.Busy), 8'd0);

      // Reset during EXEC aborts; pointer returns to 1 so Req0 wins the tie
      drive(1'b1, 4'h1, 4'h1, 2'd0, 1'b1, 4'h2, 4'h3, 2'd0);
      @(posedge clk); @(negedge clk);
      chk("pre_abort_busy", 8'(bus.Busy), 8'd1);
      chk("pre_abort_grant", 8'(bus.GrantId), 8'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 8'(bus.Busy), 8'd0);
      chk("abort_ack", {6'd0, bus.Ack1, bus.Ack0}, 8'd0);
      chk("abort_result", bus.Result, 8'h00);
      chk("abort_grant", 8'(bus.GrantId), 8'd0);
      @(posedge clk); @(negedge clk);
      chk("abort_no_ack", {6'd0, bus.Ack1, bus.Ack0}, 8'd0);
      rst = 1'b0;
      m_last = 1;
      m_res  = 8'h00;
      txn(0, 8'h02, 0);
      txn(1, 8'h05, 0);
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);

      // Randomized traffic against the reference model
      for (int it = 0; it < 60; it++) begin
         logic r0, r1;
         logic [3:0] a0, b0, a1, b1;
         logic [1:0] f0, f1;
         int win;
         r0 = 1'($urandom); r1 = 1'($urandom);
         a0 = 4'($urandom); b0 = 4'($urandom); f0 = 2'($urandom);
         a1 = 4'($urandom); b1 = 4'($urandom); f1 = 2'($urandom);
         drive(r0, a0, b0, f0, r1, a1, b1, f1);
         if (!r0 && !r1) begin
            @(posedge clk); @(negedge clk);
            chk("rnd_idle_busy", 8'(bus.Busy), 8'd0);
            chk("rnd_idle_ack", {6'd0, bus.Ack1, bus.Ack0}, 8'd0);
            chk("rnd_idle_result", bus.Result, m_res);
         end else begin
            win = ref_pick(r0, r1);
            txn(win, (win == 1) ? ref_alu(a1, b1, f1) : ref_alu(a0, b0, f0), 1);
         end
      end
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);

`ifdef ALU_ARB_STATS_EN
      // Counter saturation
      apply_reset();
      chk("cnt_reset0", bus.Count0, 8'h00);
      drive(1'b1, 4'h3, 4'h4, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);
      for (int k = 0; k < 300; k++) begin
         txn(0, 8'h07, 0);
         if (k == 9) chk("cnt_partial0", bus.Count0, 8'd10);
      end
      chk("cnt_sat0", bus.Count0, 8'hFF);
      chk("cnt_idle1", bus.Count1, 8'h00);
      drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0, 2'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
